// File: rtl/ss_sequencer_pkg.sv
// ss_sequencer_pkg: shared state encoding and default sizes for the save-state sequencer
package ss_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, S_SET, S_CAP, L_RD, L_HI, L_LO, FIN} state_t;
  localparam int SS_REG_COUNT = 256;
  localparam logic [7:0] SS_IDX_LAST = 8'(SS_REG_COUNT - 1);
endpackage

// File: rtl/ss_sequencer_m2_sync.sv
// ss_sequencer_m2_sync: 2-flop m2 synchroniser (clk, rst_n, m2 in) with registered rise/fall pulses out
module ss_sequencer_m2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s <= {s[1:0], m2};
      rise <= s[1] & ~s[2];
      fall <= ~s[1] & s[2];
    end
endmodule

// File: rtl/ss_sequencer.sv
// ss_sequencer: dumps mapper regs to a 256-byte buffer or restores them paced to M2 (host start/busy/done/err, buffer port, mapper ss_* port)
module ss_sequencer
  import ss_sequencer_pkg::*;
#(
  parameter int REG_COUNT = SS_REG_COUNT,
  parameter int M2_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m2,
  input  logic       start_save,
  input  logic       start_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] buf_addr,
  output logic       buf_we,
  output logic [7:0] buf_wdat,
  input  logic [7:0] buf_rdat,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat
);
  localparam logic [7:0] LAST = 8'(REG_COUNT - 1);
  localparam int TW = $clog2(M2_TIMEOUT + 1);
  state_t state, state_nx;
  logic [7:0] idx, idx_nx;
  logic [TW-1:0] tcnt;
  logic rise, fall, last, wait_st, tmo;
  ss_sequencer_m2_sync u_m2_sync (.clk(clk), .rst_n(rst_n), .m2(m2), .rise(rise), .fall(fall));
  assign last = idx == LAST;
  assign wait_st = state == L_HI || state == L_LO;
  assign tmo = wait_st && tcnt == TW'(M2_TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    case (state)
      IDLE: state_nx = start_save ? S_SET : start_load ? L_RD : IDLE;
      S_SET: state_nx = S_CAP;
      S_CAP: begin
        state_nx = last ? FIN : S_SET;
        idx_nx = last ? idx : idx + 8'd1;
      end
      L_RD: state_nx = L_HI;
      L_HI: state_nx = tmo ? IDLE : rise ? L_LO : L_HI;
      L_LO: begin
        state_nx = tmo ? IDLE : !fall ? L_LO : last ? FIN : L_RD;
        idx_nx = (!tmo && fall && !last) ? idx + 8'd1 : idx;
      end
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state_nx == IDLE) idx_nx = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      tcnt <= '0;
      ss_wdat <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      tcnt <= (state_nx != state) ? '0 : tcnt + TW'(1);
      if (state == L_RD) ss_wdat <= buf_rdat;
      done <= state == FIN || tmo;
      err <= (state == IDLE && (start_save || start_load)) ? 1'b0 : err | tmo;
    end
  // During L_LO the buffer address runs one ahead so the registered read of the next byte is ready by L_RD.
  assign buf_addr = (state == L_LO) ? idx + 8'd1 : idx;
  assign busy = state != IDLE;
  assign ss_act = state != IDLE && state != FIN;
  assign ss_we = wait_st;
  assign buf_we = state == S_CAP;
  assign buf_wdat = buf_we ? ss_rdat : '0;
  assign ss_addr = idx;
endmodule
